// File: rtl/cpu10_pkg.sv
// Shared types and constants for the 10-bit core.
// Datapath widths, forwarding select codes and hazard FSM states.
package cpu10_pkg;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_WB   = 2'd1,
        FWD_HIST = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding select for one EX operand: WB beats HIST beats RF.
// Ports: i_rs source addr; WB/HIST candidates; o_data value, o_sel source.
module fwd_mux
    import cpu10_pkg::*;
(
    input  logic [ADDR_W-1:0] i_rs,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_hist_valid,
    input  logic [ADDR_W-1:0] i_hist_addr,
    input  logic [DATA_W-1:0] i_hist_data,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_sel
);

    logic w_wb_hit;
    logic w_hist_hit;

    assign w_wb_hit   = i_wb_we && (i_wb_addr == i_rs);
    assign w_hist_hit = i_hist_valid && (i_hist_addr == i_rs);

    // The WB slot is younger than history, so it must win on a double hit.
    always_comb begin
        o_data = i_rf_data;
        o_sel  = FWD_RF;
        if (w_wb_hit) begin
            o_data = i_wb_data;
            o_sel  = FWD_WB;
        end else if (w_hist_hit) begin
            o_data = i_hist_data;
            o_sel  = FWD_HIST;
        end
    end

endmodule

// File: rtl/wb_hazard_ctrl.sv
// Writeback port, EX operand forwarding and load-use stall generation.
// Ports: latched WB slot in, EX/ID addrs in; RF write, fwd_*, stall_req, stall_count out.
module wb_hazard_ctrl
    import cpu10_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              gp_reg_wb,
    input  logic              mem_re,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_stall,
    input  logic [ADDR_W-1:0] ex_rs1,
    input  logic [ADDR_W-1:0] ex_rs2,
    input  logic [DATA_W-1:0] ex_rf_a,
    input  logic [DATA_W-1:0] ex_rf_b,
    input  logic              ex_mem_re,
    input  logic              ex_reg_wb,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_uses_rs2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] fwd_a,
    output logic [DATA_W-1:0] fwd_b,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              stall_req,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [2:0] HOLD_INIT = 3'(STALL_CYCLES - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [2:0]        r_hold;
    logic [2:0]        w_hold_nxt;
    logic              r_hist_valid;
    logic [ADDR_W-1:0] r_hist_addr;
    logic [DATA_W-1:0] r_hist_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_hazard;
    logic              w_stall;

    // Writes are suppressed while reset is held so nothing lands in the RF.
    assign rf_we    = gp_reg_wb & ~wb_stall & reset;
    assign rf_waddr = wb_addr;
    assign rf_wdata = mem_re ? ram_rdata : alu_result;

    fwd_mux u_fwd_a (
        .i_rs        (ex_rs1),
        .i_wb_we     (rf_we),
        .i_wb_addr   (wb_addr),
        .i_wb_data   (rf_wdata),
        .i_hist_valid(r_hist_valid),
        .i_hist_addr (r_hist_addr),
        .i_hist_data (r_hist_data),
        .i_rf_data   (ex_rf_a),
        .o_data      (fwd_a),
        .o_sel       (fwd_sel_a)
    );

    fwd_mux u_fwd_b (
        .i_rs        (ex_rs2),
        .i_wb_we     (rf_we),
        .i_wb_addr   (wb_addr),
        .i_wb_data   (rf_wdata),
        .i_hist_valid(r_hist_valid),
        .i_hist_addr (r_hist_addr),
        .i_hist_data (r_hist_data),
        .i_rf_data   (ex_rf_b),
        .o_data      (fwd_b),
        .o_sel       (fwd_sel_b)
    );

    assign w_hazard = ex_mem_re & ex_reg_wb &
                      ((ex_rd == id_rs1) |
                       (id_uses_rs2 & (ex_rd == id_rs2)));

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_stall     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall = w_hazard;
                // Single-bubble stalls never leave RUN.
                if (w_hazard && (STALL_CYCLES > 1)) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                w_stall = 1'b1;
                if (r_hold == 3'd1) begin
                    w_state_nxt = ST_RUN;
                    w_hold_nxt  = 3'd0;
                end else begin
                    w_hold_nxt  = r_hold - 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_hold_nxt  = 3'd0;
            end
        endcase
    end

    assign stall_req   = w_stall & reset;
    assign stall_count = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_hold       <= 3'd0;
            r_hist_valid <= 1'b0;
            r_hist_addr  <= '0;
            r_hist_data  <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_hist_valid <= rf_we;
            if (rf_we) begin
                r_hist_addr <= wb_addr;
                r_hist_data <= rf_wdata;
            end
            if (stall_req && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_hazard_ctrl.sv
// Directed bench for wb_hazard_ctrl: one instance with 1-bubble stalls,
// one with 3-bubble stalls, sharing all inputs except the EX load flag.
module tb_wb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] alu_result, ram_rdata, ex_rf_a, ex_rf_b;
    logic       gp_reg_wb, mem_re, wb_stall;
    logic [2:0] wb_addr, ex_rs1, ex_rs2, ex_rd, id_rs1, id_rs2;
    logic       ex_mem_re1, ex_mem_re3, ex_reg_wb, id_uses_rs2;

    logic       rf_we1, rf_we3, stall1, stall3;
    logic [2:0] waddr1, waddr3;
    logic [9:0] wdata1, wdata3, fa1, fb1, fa3, fb3;
    logic [1:0] sa1, sb1, sa3, sb3;
    logic [7:0] cnt1, cnt3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset),
        .alu_result(alu_result), .ram_rdata(ram_rdata),
        .gp_reg_wb(gp_reg_wb), .mem_re(mem_re),
        .wb_addr(wb_addr), .wb_stall(wb_stall),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rf_a(ex_rf_a), .ex_rf_b(ex_rf_b),
        .ex_mem_re(ex_mem_re1), .ex_reg_wb(ex_reg_wb), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .rf_we(rf_we1), .rf_waddr(waddr1), .rf_wdata(wdata1),
        .fwd_a(fa1), .fwd_b(fb1), .fwd_sel_a(sa1), .fwd_sel_b(sb1),
        .stall_req(stall1), .stall_count(cnt1)
    );

    wb_hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .reset(reset),
        .alu_result(alu_result), .ram_rdata(ram_rdata),
        .gp_reg_wb(gp_reg_wb), .mem_re(mem_re),
        .wb_addr(wb_addr), .wb_stall(wb_stall),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rf_a(ex_rf_a), .ex_rf_b(ex_rf_b),
        .ex_mem_re(ex_mem_re3), .ex_reg_wb(ex_reg_wb), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .rf_we(rf_we3), .rf_waddr(waddr3), .rf_wdata(wdata3),
        .fwd_a(fa3), .fwd_b(fb3), .fwd_sel_a(sa3), .fwd_sel_b(sb3),
        .stall_req(stall3), .stall_count(cnt3)
    );

    task automatic check(input string tag, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and are sampled
    // away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        alu_result = '0; ram_rdata = '0; ex_rf_a = '0; ex_rf_b = '0;
        gp_reg_wb = 0; mem_re = 0; wb_stall = 0; wb_addr = '0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        ex_mem_re1 = 0; ex_mem_re3 = 0; ex_reg_wb = 0; id_uses_rs2 = 0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst_rf_we", 16'(rf_we1), 16'h0);
        check("rst_stall", 16'(stall1), 16'h0);
        check("rst_cnt1", 16'(cnt1), 16'h0);
        check("rst_cnt3", 16'(cnt3), 16'h0);
        check("rst_sel_a", 16'(sa1), 16'h0);

        // 1: ALU write
        alu_result = 10'h155; gp_reg_wb = 1; mem_re = 0; wb_addr = 3'd3;
        #1;
        check("alu_we", 16'(rf_we1), 16'h1);
        check("alu_waddr", 16'(waddr1), 16'h3);
        check("alu_wdata", 16'(wdata1), 16'h155);

        // 2: load write
        ram_rdata = 10'h2AA; alu_result = 10'h001; mem_re = 1;
        #1;
        check("ld_wdata", 16'(wdata1), 16'h2AA);

        // 3: forward priority
        mem_re = 0; alu_result = 10'h011; wb_addr = 3'd5;
        step();
        alu_result = 10'h022; ex_rs1 = 3'd5; ex_rs2 = 3'd5;
        ex_rf_a = 10'h3FF; ex_rf_b = 10'h3FE;
        #1;
        check("fwd_wb_a", 16'(fa1), 16'h022);
        check("fwd_wb_b", 16'(fb1), 16'h022);
        check("sel_wb_a", 16'(sa1), 16'h1);
        check("sel_wb_b", 16'(sb1), 16'h1);
        step();
        gp_reg_wb = 0;
        #1;
        check("fwd_hist_a", 16'(fa1), 16'h022);
        check("sel_hist_b", 16'(sb1), 16'h2);
        step();
        check("fwd_rf_a", 16'(fa1), 16'h3FF);
        check("sel_rf_b", 16'(sb1), 16'h0);

        // 4: load-use, one bubble
        ex_reg_wb = 1; ex_rd = 3'd2; id_rs1 = 3'd2; ex_mem_re1 = 1;
        #1;
        check("lu1_stall", 16'(stall1), 16'h1);
        check("lu1_cnt0", 16'(cnt1), 16'h0);
        check("lu1_other", 16'(stall3), 16'h0);
        step();
        ex_mem_re1 = 0;
        #1;
        check("lu1_clear", 16'(stall1), 16'h0);
        check("lu1_cnt1", 16'(cnt1), 16'h1);
        ex_mem_re1 = 1; id_uses_rs2 = 0; id_rs2 = 3'd2; id_rs1 = 3'd4;
        #1;
        check("rs2_unused", 16'(stall1), 16'h0);
        id_uses_rs2 = 1;
        #1;
        check("rs2_used", 16'(stall1), 16'h1);
        ex_mem_re1 = 0;
        step();
        check("lu1_cnt_hold", 16'(cnt1), 16'h1);

        // 5: load-use, three bubbles
        id_rs1 = 3'd2; id_uses_rs2 = 0; ex_mem_re3 = 1;
        #1;
        check("lu3_c0", 16'(stall3), 16'h1);
        step();
        ex_mem_re3 = 0;
        #1;
        check("lu3_c1", 16'(stall3), 16'h1);
        step();
        check("lu3_c2", 16'(stall3), 16'h1);
        step();
        check("lu3_done", 16'(stall3), 16'h0);
        check("lu3_cnt", 16'(cnt3), 16'h3);
        ex_mem_re3 = 1;
        #1;
        check("lu3b_c0", 16'(stall3), 16'h1);
        step();
        ex_mem_re3 = 0; reset = 0;
        step();
        check("rst_hold_stall", 16'(stall3), 16'h0);
        check("rst_hold_cnt3", 16'(cnt3), 16'h0);
        check("rst_hold_cnt1", 16'(cnt1), 16'h0);
        reset = 1;
        step();
        check("post_rst_run", 16'(stall3), 16'h0);

        // 6: bubble slot
        wb_stall = 1; gp_reg_wb = 1; wb_addr = 3'd1; alu_result = 10'h0AA;
        ex_rs1 = 3'd1; ex_rf_a = 10'h123;
        #1;
        check("bub_we", 16'(rf_we1), 16'h0);
        check("bub_fwd", 16'(fa1), 16'h123);
        check("bub_sel", 16'(sa1), 16'h0);
        step();
        wb_stall = 0; gp_reg_wb = 0;
        #1;
        check("bub_hist", 16'(sa1), 16'h0);

        // Counter saturation under continuous stalls
        ex_mem_re1 = 1; ex_mem_re3 = 1;
        repeat (260) step();
        check("sat1", 16'(cnt1), 16'hFF);
        check("sat3", 16'(cnt3), 16'hFF);
        repeat (5) step();
        check("sat1_hold", 16'(cnt1), 16'hFF);
        check("sat_stall", 16'(stall1), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
